// File: rtl/sha256_padder.sv
// sha256_padder: copies an N-word message from src_addr to dst_addr and
// appends SHA-256 padding (0x80000000 marker, zero fill, 64-bit bit length)
// so the image at dst_addr is exactly 16*B words long.
//
// Memory handshake: the memory is synchronous with one cycle of read
// latency. The address presented in RD comes back on memory_read_data
// during the following WR cycle. That word is forwarded straight to
// memory_write_data while enable_write is high. Every other output is a
// registered FSM output.
module sha256_padder #(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [31:0] memory_read_data,
    output logic        done,
    output logic        memory_clk,
    output logic        enable_write,
    output logic [15:0] memory_addr,
    output logic [31:0] memory_write_data,
    output logic [7:0]  num_blocks,
    output logic [2:0]  dbg_state
);

    localparam int          BLOCKS   = (NUM_OF_WORDS + 18) / 16;
    localparam logic [15:0] N_W      = 16'(NUM_OF_WORDS);
    localparam logic [15:0] TOTAL_W  = 16'(16 * BLOCKS);
    // Index of the last zero-fill word; the two length words follow it.
    localparam logic [15:0] LAST_PAD = TOTAL_W - 16'd3;
    localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);
    localparam logic [31:0] PAD_ONE  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_PAD    = 3'd3,
        S_LEN_HI = 3'd4,
        S_LEN_LO = 3'd5
    } state_t;

    state_t      state_q;
    logic [15:0] i_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [15:0] i_inc;

    assign i_inc = i_q + 16'd1;

    // Padding FSM: sequences the reads, the copies, the padding and the length words.
    // It also registers the address, strobe and data for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= 16'd0;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            addr_q  <= 16'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        i_q     <= 16'd0;
                        addr_q  <= src_addr;
                        we_q    <= 1'b0;
                        wdata_q <= 32'd0;
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    addr_q  <= dst_q + i_q;
                    we_q    <= 1'b1;
                    state_q <= S_WR;
                end
                S_WR: begin
                    i_q <= i_inc;
                    if (i_inc < N_W) begin
                        addr_q  <= src_q + i_inc;
                        we_q    <= 1'b0;
                        state_q <= S_RD;
                    end else begin
                        // The first padding word is always the 0x80000000 marker.
                        addr_q  <= dst_q + i_inc;
                        we_q    <= 1'b1;
                        wdata_q <= PAD_ONE;
                        state_q <= S_PAD;
                    end
                end
                S_PAD: begin
                    i_q     <= i_inc;
                    addr_q  <= dst_q + i_inc;
                    we_q    <= 1'b1;
                    wdata_q <= 32'd0;
                    if (i_q == LAST_PAD) begin
                        state_q <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    addr_q  <= addr_q + 16'd1;
                    we_q    <= 1'b1;
                    wdata_q <= LEN_BITS;
                    state_q <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    i_q     <= 16'd0;
                    addr_q  <= 16'd0;
                    we_q    <= 1'b0;
                    wdata_q <= 32'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    i_q     <= 16'd0;
                    addr_q  <= 16'd0;
                    we_q    <= 1'b0;
                    wdata_q <= 32'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done              = (state_q == S_IDLE);
    assign memory_clk        = clk;
    assign enable_write      = we_q;
    assign memory_addr       = addr_q;
    assign memory_write_data = (state_q == S_WR) ? memory_read_data : wdata_q;
    assign num_blocks        = 8'(BLOCKS);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: four padder instances with N = 40, 13, 14 and 16. They share
// a read-only random source memory, and the writes of each instance are logged.
// Padded images are compared against a word-level model of the padding rule.
module tb_sha256_padder;

    localparam int NI = 4;

    function automatic int n_of(input int k);
        case (k)
            0:       return 40;
            1:       return 13;
            2:       return 14;
            default: return 16;
        endcase
    endfunction

    function automatic int blocks_of(input int n);
        return (n + 18) / 16;
    endfunction

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_r   [NI];
    logic        start_r [NI];
    logic [15:0] src_r   [NI];
    logic [15:0] dst_r   [NI];
    logic [31:0] rdata_r [NI];
    logic        done_w  [NI];
    logic        mclk_w  [NI];
    logic        we_w    [NI];
    logic [15:0] addr_w  [NI];
    logic [31:0] wdata_w [NI];
    logic [7:0]  nb_w    [NI];
    logic [2:0]  st_w    [NI];

    logic [31:0] srcmem [65536];
    logic [47:0] wlog [NI][$];
    int          busy_cnt [NI] = '{0, 0, 0, 0};
    int          idle_bad [NI] = '{0, 0, 0, 0};

    int n_vec = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_padder #(.NUM_OF_WORDS(n_of(g))) u_dut (
            .clk               (clk),
            .rst               (rst_r[g]),
            .start             (start_r[g]),
            .src_addr          (src_r[g]),
            .dst_addr          (dst_r[g]),
            .memory_read_data  (rdata_r[g]),
            .done              (done_w[g]),
            .memory_clk        (mclk_w[g]),
            .enable_write      (we_w[g]),
            .memory_addr       (addr_w[g]),
            .memory_write_data (wdata_w[g]),
            .num_blocks        (nb_w[g]),
            .dbg_state         (st_w[g])
        );
    end

    // synchronous read memory, one cycle latency
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) rdata_r[k] <= srcmem[addr_w[k]];
    end

    // write logger and busy / idle-output monitor
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (we_w[k] === 1'b1) wlog[k].push_back({addr_w[k], wdata_w[k]});
            if (done_w[k] !== 1'b1) busy_cnt[k] = busy_cnt[k] + 1;
            if (done_w[k] === 1'b1 && (we_w[k] !== 1'b0 || addr_w[k] !== 16'd0 || wdata_w[k] !== 32'd0))
                idle_bad[k] = idle_bad[k] + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one start pulse, optional stray start mid-run, bounded wait for done
    task automatic run_op(input int k, input logic [15:0] src, input logic [15:0] dst,
                          input bit pulse_mid, output int busy, output int wbase, output bit timeout);
        int b0;
        @(negedge clk);
        wbase = wlog[k].size();
        b0 = busy_cnt[k];
        src_r[k] = src;
        dst_r[k] = dst;
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
        src_r[k] = 16'($urandom);
        dst_r[k] = 16'($urandom);
        timeout = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (done_w[k] === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (pulse_mid && c == 10) start_r[k] = 1'b1;
            if (pulse_mid && c == 11) start_r[k] = 1'b0;
            @(negedge clk);
        end
        start_r[k] = 1'b0;
        busy = busy_cnt[k] - b0;
    endtask

    // scoreboard: expected padded image built from the padding rule
    task automatic check_image(input int k, input logic [15:0] src, input logic [15:0] dst, input int base);
        int n;
        int tot;
        logic [47:0] exp_q[$];
        logic [31:0] d;
        n = n_of(k);
        tot = 16 * blocks_of(n);
        for (int j = 0; j < tot; j++) begin
            if (j < n) d = srcmem[16'(src + 16'(j))];
            else if (j == n) d = 32'h8000_0000;
            else if (j == tot - 1) d = 32'(n * 32);
            else d = 32'd0;
            exp_q.push_back({16'(dst + 16'(j)), d});
        end
        for (int j = 0; j < tot; j++) begin
            if (base + j < wlog[k].size())
                check($sformatf("img%0d_w%0d", k, j), wlog[k][base + j], exp_q[j]);
            else
                check($sformatf("img%0d_w%0d_missing", k, j), 64'd1, 64'd0);
        end
    endtask

    typedef struct {
        int          k;
        logic [15:0] src;
        logic [15:0] dst;
        int          exp_blocks;
        logic [31:0] exp_len;
        int          exp_busy;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int busy;
        int wbase;
        int b0;
        bit tmo;
        int k;
        logic [15:0] s;
        logic [15:0] d;

        tbl[0] = '{0, 16'h0000, 16'h0100, 3, 32'h0000_0500, 88};
        tbl[1] = '{1, 16'h0040, 16'h0300, 1, 32'h0000_01A0, 29};
        tbl[2] = '{2, 16'h1000, 16'h2000, 2, 32'h0000_01C0, 46};
        tbl[3] = '{3, 16'h0200, 16'hFFF8, 2, 32'h0000_0200, 48};

        for (int a = 0; a < 65536; a++) srcmem[a] = $urandom;
        for (int i = 0; i < NI; i++) begin
            rst_r[i] = 1'b1;
            start_r[i] = 1'b0;
            src_r[i] = 16'd0;
            dst_r[i] = 16'd0;
        end
        repeat (3) @(negedge clk);

        // reset state
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_done%0d", i), done_w[i], 1);
            check($sformatf("rst_we%0d", i), we_w[i], 0);
            check($sformatf("rst_addr%0d", i), addr_w[i], 0);
            check($sformatf("rst_wdata%0d", i), wdata_w[i], 0);
            check($sformatf("num_blocks%0d", i), nb_w[i], blocks_of(n_of(i)));
        end
        check("mclk_low", mclk_w[0], 0);
        @(posedge clk);
        #1;
        check("mclk_high", mclk_w[0], 1);
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst_r[i] = 1'b0;

        // directed table
        for (int t = 0; t < 4; t++) begin
            k = tbl[t].k;
            run_op(k, tbl[t].src, tbl[t].dst, (k == 3), busy, wbase, tmo);
            check($sformatf("tbl%0d_timeout", t), tmo, 0);
            check($sformatf("tbl%0d_blocks", t), nb_w[k], tbl[t].exp_blocks);
            check($sformatf("tbl%0d_busy", t), busy, tbl[t].exp_busy);
            check($sformatf("tbl%0d_count", t), wlog[k].size() - wbase, 16 * tbl[t].exp_blocks);
            if (wlog[k].size() > 0)
                check($sformatf("tbl%0d_lenword", t), wlog[k][wlog[k].size() - 1][31:0], tbl[t].exp_len);
            check_image(k, tbl[t].src, tbl[t].dst, wbase);
            repeat (3) @(negedge clk);
            check($sformatf("tbl%0d_stays_idle", t), done_w[k], 1);
        end

        // randomized ops
        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, NI - 1);
            s = 16'($urandom_range(0, 65535));
            d = 16'($urandom_range(0, 65535));
            run_op(k, s, d, 1'b0, busy, wbase, tmo);
            check($sformatf("rnd%0d_timeout", r), tmo, 0);
            check($sformatf("rnd%0d_busy", r), busy, n_of(k) + 16 * blocks_of(n_of(k)));
            check($sformatf("rnd%0d_count", r), wlog[k].size() - wbase, 16 * blocks_of(n_of(k)));
            check_image(k, s, d, wbase);
        end

        // reset in cycle 20 of the copy, start ignored while reset is high
        @(negedge clk);
        src_r[0] = 16'h0000;
        dst_r[0] = 16'h0100;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy", done_w[0], 0);
        rst_r[0] = 1'b1;
        start_r[0] = 1'b1;
        @(negedge clk);
        check("midrst_done", done_w[0], 1);
        check("midrst_we", we_w[0], 0);
        check("midrst_addr", addr_w[0], 0);
        check("midrst_wdata", wdata_w[0], 0);
        @(negedge clk);
        check("rst_start_ignored", done_w[0], 1);
        start_r[0] = 1'b0;
        rst_r[0] = 1'b0;
        @(negedge clk);
        check("post_rst_idle", done_w[0], 1);
        run_op(0, 16'h0000, 16'h0100, 1'b0, busy, wbase, tmo);
        check("after_rst_timeout", tmo, 0);
        check("after_rst_busy", busy, 88);
        check("after_rst_count", wlog[0].size() - wbase, 48);
        check_image(0, 16'h0000, 16'h0100, wbase);

        // start held high: back-to-back runs with one idle cycle between
        @(negedge clk);
        wbase = wlog[1].size();
        b0 = busy_cnt[1];
        src_r[1] = 16'h0500;
        dst_r[1] = 16'h0600;
        start_r[1] = 1'b1;
        tmo = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done_w[1] === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        check("held_first_timeout", tmo, 0);
        check("held_first_busy", busy_cnt[1] - b0, 29);
        @(negedge clk);
        check("held_restart", done_w[1], 0);
        start_r[1] = 1'b0;
        tmo = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (done_w[1] === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("held_second_timeout", tmo, 0);
        check("held_total_busy", busy_cnt[1] - b0, 58);
        check("held_count", wlog[1].size() - wbase, 32);
        check_image(1, 16'h0500, 16'h0600, wbase);
        check_image(1, 16'h0500, 16'h0600, wbase + 16);

        repeat (2) @(negedge clk);
        check("idle_outputs", idle_bad[0] + idle_bad[1] + idle_bad[2] + idle_bad[3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
